// File: rtl/mac_driver.sv
// rtl/mac_driver.sv - loads 28 MAC node operands, fires the node, returns two results
// Results are captured from the node and streamed out as two 17-bit words.
module mac_driver #(
  parameter int WAIT_MAX = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [4:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic signed [4:0]  x0,
  output logic signed [4:0]  x1,
  output logic signed [4:0]  x2,
  output logic signed [4:0]  x3,
  output logic signed [4:0]  w04,
  output logic signed [4:0]  w05,
  output logic signed [4:0]  w06,
  output logic signed [4:0]  w07,
  output logic signed [4:0]  w14,
  output logic signed [4:0]  w15,
  output logic signed [4:0]  w16,
  output logic signed [4:0]  w17,
  output logic signed [4:0]  w24,
  output logic signed [4:0]  w25,
  output logic signed [4:0]  w26,
  output logic signed [4:0]  w27,
  output logic signed [4:0]  w34,
  output logic signed [4:0]  w35,
  output logic signed [4:0]  w36,
  output logic signed [4:0]  w37,
  output logic signed [4:0]  w48,
  output logic signed [4:0]  w58,
  output logic signed [4:0]  w49,
  output logic signed [4:0]  w59,
  output logic signed [4:0]  w68,
  output logic signed [4:0]  w69,
  output logic signed [4:0]  w78,
  output logic signed [4:0]  w79,
  output logic               in_ready,
  input  logic signed [16:0] out0,
  input  logic signed [16:0] out1,
  input  logic               out0_ready,
  input  logic               out1_ready,
  output logic signed [16:0] r_data,
  output logic               r_valid,
  input  logic               r_ready,
  output logic               err
);

  typedef enum logic [2:0] {LOAD, FIRE, WAIT, SEND0, SEND1} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2:0]         wcnt_q, wcnt_d;
  logic signed [4:0]  regs_q [28];
  logic signed [4:0]  regs_d [28];
  logic signed [16:0] hold0_q, hold0_d;
  logic signed [16:0] hold1_q, hold1_d;
  logic signed [16:0] r_data_q, r_data_d;
  logic               r_valid_q, r_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    regs_d    = regs_q;
    hold0_d   = hold0_q;
    hold1_d   = hold1_q;
    r_data_d  = r_data_q;
    r_valid_d = r_valid_q;
    err_d     = err_q;
    case (state_q)
      LOAD: begin
        if (s_valid) begin
          regs_d[cnt_q] = s_data;
          if (cnt_q == 5'd27) begin
            cnt_d   = 5'd0;
            state_d = FIRE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      FIRE: state_d = WAIT;
      WAIT: begin
        // Both flags are required; a lone flag counts as another wait cycle.
        if (out0_ready && out1_ready) begin
          hold0_d   = out0;
          hold1_d   = out1;
          r_data_d  = out0;
          r_valid_d = 1'b1;
          wcnt_d    = 3'd0;
          state_d   = SEND0;
        end else if (wcnt_q == WAIT_MAX[2:0]) begin
          err_d   = 1'b1;
          wcnt_d  = 3'd0;
          state_d = LOAD;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      SEND0: begin
        if (r_ready) begin
          r_data_d = hold1_q;
          state_d  = SEND1;
        end
      end
      SEND1: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          state_d   = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
    in_ready_d = (state_d == FIRE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      cnt_q      <= 5'd0;
      wcnt_q     <= 3'd0;
      for (int i = 0; i < 28; i++) regs_q[i] <= '0;
      hold0_q    <= '0;
      hold1_q    <= '0;
      r_data_q   <= '0;
      r_valid_q  <= 1'b0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      regs_q     <= regs_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
      r_data_q   <= r_data_d;
      r_valid_q  <= r_valid_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
    end
  end

  assign s_ready  = (state_q == LOAD) && !rst;
  assign in_ready = in_ready_q;
  assign r_data   = r_data_q;
  assign r_valid  = r_valid_q;
  assign err      = err_q;

  assign x0  = regs_q[0];   assign x1  = regs_q[1];
  assign x2  = regs_q[2];   assign x3  = regs_q[3];
  assign w04 = regs_q[4];   assign w05 = regs_q[5];
  assign w06 = regs_q[6];   assign w07 = regs_q[7];
  assign w14 = regs_q[8];   assign w15 = regs_q[9];
  assign w16 = regs_q[10];  assign w17 = regs_q[11];
  assign w24 = regs_q[12];  assign w25 = regs_q[13];
  assign w26 = regs_q[14];  assign w27 = regs_q[15];
  assign w34 = regs_q[16];  assign w35 = regs_q[17];
  assign w36 = regs_q[18];  assign w37 = regs_q[19];
  assign w48 = regs_q[20];  assign w58 = regs_q[21];
  assign w49 = regs_q[22];  assign w59 = regs_q[23];
  assign w68 = regs_q[24];  assign w69 = regs_q[25];
  assign w78 = regs_q[26];  assign w79 = regs_q[27];

endmodule

// File: tb/tb_mac_driver.sv
// tb/tb_mac_driver.sv - directed and random frames for mac_driver with an attached MAC node model
module tb_mac_driver;
  logic clk = 1'b0;
  logic rst;
  logic signed [4:0]  s_data;
  logic s_valid, s_ready;
  logic signed [4:0]  x0, x1, x2, x3;
  logic signed [4:0]  w04, w05, w06, w07, w14, w15, w16, w17;
  logic signed [4:0]  w24, w25, w26, w27, w34, w35, w36, w37;
  logic signed [4:0]  w48, w58, w49, w59, w68, w69, w78, w79;
  logic in_ready;
  logic signed [16:0] out0, out1;
  logic out0_ready, out1_ready;
  logic signed [16:0] r_data;
  logic r_valid, r_ready, err;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mac_driver #(.WAIT_MAX(7)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .w04(w04), .w05(w05), .w06(w06), .w07(w07),
    .w14(w14), .w15(w15), .w16(w16), .w17(w17),
    .w24(w24), .w25(w25), .w26(w26), .w27(w27),
    .w34(w34), .w35(w35), .w36(w36), .w37(w37),
    .w48(w48), .w58(w58), .w49(w49), .w59(w59),
    .w68(w68), .w69(w69), .w78(w78), .w79(w79),
    .in_ready(in_ready), .out0(out0), .out1(out1),
    .out0_ready(out0_ready), .out1_ready(out1_ready),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready), .err(err)
  );

  // MAC node: 4 inputs -> 4 ReLU hidden nodes (4..7) -> outputs 8 and 9, ready 2 edges after the start strobe.
  function automatic int m(input logic signed [4:0] a, input logic signed [4:0] b);
    return int'(a) * int'(b);
  endfunction
  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  int h4, h5, h6, h7, n8, n9;
  assign h4 = relu(m(x0, w04) + m(x1, w14) + m(x2, w24) + m(x3, w34));
  assign h5 = relu(m(x0, w05) + m(x1, w15) + m(x2, w25) + m(x3, w35));
  assign h6 = relu(m(x0, w06) + m(x1, w16) + m(x2, w26) + m(x3, w36));
  assign h7 = relu(m(x0, w07) + m(x1, w17) + m(x2, w27) + m(x3, w37));
  assign n8 = h4 * int'(w48) + h5 * int'(w58) + h6 * int'(w68) + h7 * int'(w78);
  assign n9 = h4 * int'(w49) + h5 * int'(w59) + h6 * int'(w69) + h7 * int'(w79);

  logic [1:0] node_p;
  logic node_rdy;
  logic signed [16:0] node_o0, node_o1;
  int node_mode = 0;  // 0 normal, 1 never ready, 2 only out0_ready

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      node_p <= 2'b00; node_rdy <= 1'b0; node_o0 <= '0; node_o1 <= '0;
    end else begin
      node_p <= {node_p[0], in_ready};
      if (in_ready) node_rdy <= 1'b0;
      if (node_p[1]) begin
        node_o0  <= n8[16:0];
        node_o1  <= n9[16:0];
        node_rdy <= 1'b1;
      end
    end
  end
  assign out0 = node_o0;
  assign out1 = node_o1;
  assign out0_ready = node_rdy && (node_mode != 1);
  assign out1_ready = node_rdy && (node_mode == 0);

  logic signed [4:0] dout [28];
  assign dout = '{x0, x1, x2, x3, w04, w05, w06, w07, w14, w15, w16, w17,
                  w24, w25, w26, w27, w34, w35, w36, w37,
                  w48, w58, w49, w59, w68, w69, w78, w79};

  logic signed [4:0] wd [28];

  // Reference: word k feeds hidden node j from input i at 4+4i+j; output weights follow the pair order.
  function automatic int ref_out(input int o);
    int acc, h, widx;
    acc = 0;
    for (int j = 0; j < 4; j++) begin
      h = 0;
      for (int i = 0; i < 4; i++) h += int'(wd[i]) * int'(wd[4 + 4 * i + j]);
      if (h < 0) h = 0;
      widx = (j < 2) ? (20 + j + 2 * o) : (24 + 2 * (j - 2) + o);
      acc += h * int'(wd[widx]);
    end
    return acc;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_frame(input int xv, input int wv);
    for (int k = 0; k < 28; k++) wd[k] = (k < 4) ? 5'(xv) : 5'(wv);
  endtask

  task automatic set_random();
    for (int k = 0; k < 28; k++) wd[k] = 5'($urandom_range(31, 0));
  endtask

  // Returns on the negedge after the n-th transfer edge.
  task automatic load_words(input int n, input bit toggle);
    int idx, cyc;
    idx = 0; cyc = 0;
    while (idx < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      s_valid = !(toggle && cyc[0] == 1'b0);
      s_data  = wd[idx];
      if (s_valid && s_ready) idx++;
      if (idx < n || !s_valid) chk("in_ready_during_load", in_ready, 0);
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("load_count", idx, n);
  endtask

  task automatic run_frame(input bit toggle, input int stall);
    int lat, irc, e0, e1, mis;
    e0 = ref_out(0); e1 = ref_out(1);
    load_words(28, toggle);
    chk("fire_in_ready", in_ready, 1);
    mis = 0;
    for (int k = 0; k < 28; k++) if (dout[k] !== wd[k]) mis++;
    chk("reg_order_mismatches", mis, 0);
    lat = 0; irc = 0;
    while (!r_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (in_ready) irc++;
    end
    chk("capture_latency", lat, 4);
    chk("in_ready_after_fire", irc, 0);
    chk("send0_data", $signed(r_data), e0);
    for (int k = 0; k < stall; k++) begin
      r_ready = 1'b0;
      @(negedge clk);
      chk("stall_valid", r_valid, 1);
      chk("stall_data", $signed(r_data), e0);
    end
    r_ready = 1'b1;
    @(negedge clk);
    chk("send1_valid", r_valid, 1);
    chk("send1_data", $signed(r_data), e1);
    @(negedge clk);
    chk("done_valid", r_valid, 0);
    chk("done_s_ready", s_ready, 1);
  endtask

  task automatic run_timeout(input int mode);
    int rv;
    node_mode = mode;
    load_words(28, 1'b0);
    chk("to_fire_in_ready", in_ready, 1);
    rv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (r_valid) rv++;
      chk("to_waiting_s_ready", s_ready, 0);
    end
    @(negedge clk);
    chk("to_err", err, 1);
    chk("to_back_in_load", s_ready, 1);
    chk("to_r_valid_seen", rv + int'(r_valid), 0);
    node_mode = 0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; r_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_r_data", $signed(r_data), 0);
    chk("rst_x0", x0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1);

    set_frame(0, 0);
    for (int k = 0; k < 4; k++) wd[k] = 5'(k + 1);
    for (int k = 4; k < 28; k++) wd[k] = 5'sd1;
    run_frame(1'b0, 0);
    chk("ref_40", ref_out(0), 40);

    set_frame(-1, 1);
    run_frame(1'b0, 0);
    chk("relu_err", err, 0);

    for (int k = 0; k < 4; k++) wd[k] = 5'(k + 1);
    for (int k = 4; k < 28; k++) wd[k] = 5'sd1;
    run_frame(1'b0, 5);

    run_timeout(1);
    run_frame(1'b0, 0);
    chk("err_sticky", err, 1);
    run_timeout(2);
    chk("err_still", err, 1);

    set_random();
    load_words(10, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_x0", x0, 0);
    chk("mid_rst_w04", w04, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    set_frame(2, 1);
    run_frame(1'b0, 0);

    for (int f = 0; f < 4; f++) begin
      set_random();
      run_frame(f[0], f);
    end
    chk("final_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
